// File: rtl/lane_debounce_events_pkg.sv
// Shared defaults for the lane debounce / event block.
package lane_debounce_events_pkg;

    localparam int unsigned LDE_WIDTH         = 4;
    localparam int unsigned LDE_STABLE_CYCLES = 8;

endpackage : lane_debounce_events_pkg

// File: rtl/lane_debounce_cell.sv
// Single-lane debouncer: accepts a new level after STABLE_CYCLES consecutive
// samples that differ from the current level, with one-cycle rise/fall pulses.
module lane_debounce_cell
    import lane_debounce_events_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = LDE_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Stability counter; any sample equal to the current level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (din == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= din;
                rise  <= din;
                fall  <= ~din;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : lane_debounce_cell

// File: rtl/lane_debounce_events.sv
// Debounces WIDTH independent lanes and reports accepted level changes as
// pulses and as a coalesced event mask behind a valid/ready handshake.
module lane_debounce_events
    import lane_debounce_events_pkg::*;
#(
    parameter int unsigned WIDTH         = LDE_WIDTH,
    parameter int unsigned STABLE_CYCLES = LDE_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic             evt_overflow
);

    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] edges;
    logic             load;

    // One debouncer per lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lane_debounce_cell #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (in_data[i]),
            .level (stable_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i])
        );
    end

    assign edges = rise_pulse | fall_pulse;
    assign load  = ~evt_valid | evt_ready;

    // Event mask handshake: load pending plus fresh edges when the slot is free,
    // otherwise accumulate into pend and flag a lane that changes twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid    <= 1'b0;
            evt_mask     <= '0;
            pend         <= '0;
            evt_overflow <= 1'b0;
        end else if (load) begin
            evt_mask  <= pend | edges;
            evt_valid <= |(pend | edges);
            pend      <= '0;
        end else begin
            pend <= pend | edges;
            if (|(pend & edges)) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule : lane_debounce_events

// File: tb/tb_lane_debounce_events.sv
// Directed self-checking bench for lane_debounce_events (WIDTH=4, STABLE_CYCLES=8).
`timescale 1ns/1ps
module tb_lane_debounce_events;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic [3:0] stable_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_mask;
    logic       evt_overflow;

    int n_checks;
    int n_errors;

    lane_debounce_events #(
        .WIDTH         (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .stable_out   (stable_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_mask     (evt_mask),
        .evt_overflow (evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [3:0] rp,
                             input logic [3:0] fp, input logic v, input logic [3:0] m,
                             input logic ov);
        check({tag, ".stable"},   32'(stable_out),   32'(st));
        check({tag, ".rise"},     32'(rise_pulse),   32'(rp));
        check({tag, ".fall"},     32'(fall_pulse),   32'(fp));
        check({tag, ".valid"},    32'(evt_valid),    32'(v));
        check({tag, ".mask"},     32'(evt_mask),     32'(m));
        check({tag, ".overflow"}, 32'(evt_overflow), 32'(ov));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_data   = 4'hF;
        evt_ready = 1'b1;

        // Reset with all lanes high: everything held at zero.
        step(3);
        check_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        in_data = 4'h0;
        rst_n   = 1'b1;
        step(2);

        // Lane 0 rises: accepted on the 8th edge, event one cycle later.
        in_data = 4'h1;
        step(7);
        check_all("rise0_e7", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step(1);
        check_all("rise0_e8", 4'h1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0);
        step(1);
        check_all("rise0_e9", 4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
        step(1);
        check_all("rise0_e10", 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Glitch on lane 2 for 7 cycles: no effect.
        in_data = 4'h5;
        for (int k = 0; k < 7; k++) begin
            step(1);
            check("glitch.rise",  32'(rise_pulse), 32'h0);
            check("glitch.valid", 32'(evt_valid),  32'h0);
        end
        in_data = 4'h1;
        step(3);
        check_all("glitch_end", 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Lane 0 falls back with ready high.
        in_data = 4'h0;
        step(8);
        check_all("fall0", 4'h0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0);
        step(1);
        check_all("fall0_evt", 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
        step(1);

        // Backpressure: lane 0 then lane 3 rise while ready is low.
        evt_ready = 1'b0;
        in_data   = 4'h1;
        step(9);
        check_all("bp_first", 4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
        in_data = 4'h9;
        step(8);
        check_all("bp_rise3", 4'h9, 4'h8, 4'h0, 1'b1, 4'h1, 1'b0);
        step(2);
        check_all("bp_hold", 4'h9, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
        evt_ready = 1'b1;
        step(1);
        check_all("bp_next", 4'h9, 4'h0, 4'h0, 1'b1, 4'h8, 1'b0);
        step(1);
        check_all("bp_drain", 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Overflow: lane 1 rises, falls, rises again while ready is low.
        evt_ready = 1'b0;
        in_data   = 4'hB;
        step(9);
        check_all("ov_first", 4'hB, 4'h0, 4'h0, 1'b1, 4'h2, 1'b0);
        in_data = 4'h9;
        step(9);
        check_all("ov_pend", 4'h9, 4'h0, 4'h0, 1'b1, 4'h2, 1'b0);
        in_data = 4'hB;
        step(9);
        check_all("ov_set", 4'hB, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1);
        evt_ready = 1'b1;
        step(1);
        check_all("ov_accept", 4'hB, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1);
        step(1);
        check_all("ov_sticky", 4'hB, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Accept coincides with a lane 2 edge: new edge lands in the next mask.
        evt_ready = 1'b0;
        in_data   = 4'hA;
        step(9);
        check_all("sim_first", 4'hA, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1);
        in_data = 4'hE;
        step(8);
        check_all("sim_edge", 4'hE, 4'h4, 4'h0, 1'b1, 4'h1, 1'b1);
        evt_ready = 1'b1;
        step(1);
        check_all("sim_next", 4'hE, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1);
        step(1);
        check_all("sim_drain", 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Asynchronous reset mid-count and mid-cycle clears at once.
        in_data = 4'h0;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step(2);
        rst_n = 1'b1;
        in_data = 4'h2;
        step(5);
        check_all("post_rst", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step(3);
        check_all("post_rst_rise", 4'h2, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_lane_debounce_events
